load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine in front of a 256-word
// data memory with a combinational read port. Loads read the addressed word
// and return the selected lane, zero- or sign-extended. Stores do a
// read-modify-write: RD fetches the word, WR writes it back with the addressed
// lanes replaced. Misaligned requests go straight to ERR with no memory access.
// Optional feature macro: LSU_WORD_STORE_FASTPATH_EN. When it is defined,
// aligned word stores skip RD, because every lane gets replaced anyway.
module load_store_unit (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LSU_REQ,
   input  logic        LSU_WE,
   input  logic [1:0]  LSU_SIZE,
   input  logic        LSU_UNSIGNED,
   input  logic [31:0] LSU_ADDR,
   input  logic [31:0] LSU_WDATA,
   output logic [31:0] LSU_RDATA,
   output logic        LSU_DONE,
   output logic        LSU_BUSY,
   output logic        LSU_MISALIGN,
   output logic [7:0]  ADDR_DATA_M,
   output logic        Mem_WE,
   output logic [31:0] IN_DATA_M,
   input  logic [31:0] OUT_DATA_M
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_RESP = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  addr_m_q, addr_m_d;
   logic [31:0] in_data_q, in_data_d;
   logic [31:0] rdata_q, rdata_d;

   // Upper address bits alias onto the 1 KiB window, so they are dropped here.
   logic unused_addr_hi;
   assign unused_addr_hi = &{1'b0, LSU_ADDR[31:10]};

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic r;
      case (size)
         2'b00:   r = 1'b0;
         2'b01:   r = lo[0];
         2'b10:   r = (lo != 2'b00);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // Replace only the addressed lanes of the fetched word with the store data.
   function automatic logic [31:0] merge_lanes(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] lo);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00:   r[{lo, 3'b000} +: 8]     = wd[7:0];
         2'b01:   r[{lo[1], 4'b0000} +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   // Pick the addressed lane out of the fetched word and extend it to 32 bits.
   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (size)
         2'b00:   r = {{24{~uns & b[7]}}, b};
         2'b01:   r = {{16{~uns & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // State and the memory-facing / result registers, cleared by reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         addr_m_q  <= 8'h00;
         in_data_q <= 32'h0;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         addr_m_q  <= addr_m_d;
         in_data_q <= in_data_d;
         rdata_q   <= rdata_d;
      end
   end

   // Request attributes latched at acceptance; never observed before being loaded.
   always_ff @(posedge CLK) begin
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
   end

   // Next-state logic, register updates and state-decoded outputs.
   always_comb begin
      state_d      = state_q;
      addr_lo_d    = addr_lo_q;
      size_d       = size_q;
      we_d         = we_q;
      uns_d        = uns_q;
      wdata_d      = wdata_q;
      addr_m_d     = addr_m_q;
      in_data_d    = in_data_q;
      rdata_d      = rdata_q;
      LSU_DONE     = 1'b0;
      LSU_MISALIGN = 1'b0;
      LSU_BUSY     = 1'b1;
      Mem_WE       = 1'b0;
      case (state_q)
         S_IDLE: begin
            LSU_BUSY = 1'b0;
            if (LSU_REQ) begin
               addr_lo_d = LSU_ADDR[1:0];
               size_d    = LSU_SIZE;
               we_d      = LSU_WE;
               uns_d     = LSU_UNSIGNED;
               wdata_d   = LSU_WDATA;
               addr_m_d  = LSU_ADDR[9:2];
               if (is_misaligned(LSU_SIZE, LSU_ADDR[1:0])) begin
                  state_d = S_ERR;
               end else begin
`ifdef LSU_WORD_STORE_FASTPATH_EN
                  if (LSU_WE && (LSU_SIZE == 2'b10)) begin
                     in_data_d = LSU_WDATA;
                     state_d   = S_WR;
                  end else begin
                     state_d = S_RD;
                  end
`else
                  state_d = S_RD;
`endif
               end
            end
         end
         S_RD: begin
            if (we_q) begin
               in_data_d = merge_lanes(OUT_DATA_M, wdata_q, size_q, addr_lo_q);
               state_d   = S_WR;
            end else begin
               rdata_d = extend_load(OUT_DATA_M, size_q, addr_lo_q, uns_q);
               state_d = S_RESP;
            end
         end
         S_WR: begin
            Mem_WE  = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            LSU_DONE = 1'b1;
            state_d  = S_IDLE;
         end
         S_ERR: begin
            LSU_DONE     = 1'b1;
            LSU_MISALIGN = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign LSU_RDATA   = rdata_q;
   assign ADDR_DATA_M = addr_m_q;
   assign IN_DATA_M   = in_data_q;

endmodule
